// File: rtl/stage_monitor.sv
// stage_monitor: samples a firmware stage code and error flags from pads on a
// prescaled tick, debounces stage changes over two consecutive ticks, logs
// accepted stages in a first-word-fall-through history FIFO and latches one
// terminal verdict (pass / fail / timeout) per run.
module stage_monitor #(
    parameter int                 STAGE_W         = 8,
    parameter int                 NUM_ERR         = 1,
    parameter int                 SAMPLE_DIV      = 100,
    parameter int                 TIMEOUT_SAMPLES = 24000,
    parameter int                 TIMEOUT_MODE    = 0,
    parameter logic [STAGE_W-1:0] PASS_CODE       = 8'hFE,
    parameter int                 HIST_DEPTH      = 16
) (
    input  logic                          clock,
    input  logic                          resetb,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [STAGE_W-1:0]            stage_i,
    input  logic [NUM_ERR-1:0]            err_i,
    output logic                          stage_evt,
    output logic [STAGE_W-1:0]            stage_q,
    output logic                          done,
    output logic                          pass,
    output logic                          fail,
    output logic                          timeout,
    output logic [NUM_ERR-1:0]            err_src,
    output logic                          hist_valid,
    input  logic                          hist_ready,
    output logic [STAGE_W-1:0]            hist_data,
    output logic [$clog2(HIST_DEPTH):0]   hist_count,
    output logic                          hist_ovf
);

    localparam int PW = $clog2(SAMPLE_DIV);
    localparam int WW = $clog2(TIMEOUT_SAMPLES + 1);
    localparam int AW = $clog2(HIST_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TOUT
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [STAGE_W-1:0]   stage_s1;
    logic [STAGE_W-1:0]   stage_s2;
    logic [NUM_ERR-1:0]   err_s1;
    logic [NUM_ERR-1:0]   err_s2;

    logic [PW-1:0]        presc;
    logic [WW-1:0]        wd;
    logic [WW-1:0]        wd_inc;
    logic [STAGE_W-1:0]   cand;

    logic [STAGE_W-1:0]   mem [HIST_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    logic                 tick;
    logic                 err_any;
    logic                 accept;
    logic                 pass_hit;
    logic                 wd_zero;
    logic                 tout_hit;
    logic                 pop;
    logic                 full;
    logic                 push_ok;

    // Two-flop synchronisers for the asynchronous pad inputs; clear leaves them alone.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            stage_s1 <= '0;
            stage_s2 <= '0;
            err_s1   <= '0;
            err_s2   <= '0;
        end else begin
            stage_s1 <= stage_i;
            stage_s2 <= stage_s1;
            err_s1   <= err_i;
            err_s2   <= err_s1;
        end
    end

    // Per-tick decisions and next state; error beats stage acceptance, pass beats timeout.
    always_comb begin
        tick     = (state == S_RUN) && enable && !clear && (presc == PW'(SAMPLE_DIV - 1));
        err_any  = |err_s2;
        accept   = tick && !err_any && (stage_s2 == cand) && (stage_s2 != stage_q);
        pass_hit = accept && (stage_s2 == PASS_CODE);
        wd_zero  = accept && (TIMEOUT_MODE != 0);
        wd_inc   = wd + 1'b1;
        tout_hit = tick && !err_any && !pass_hit && !wd_zero && (wd_inc == WW'(TIMEOUT_SAMPLES));

        state_next = state;
        if (clear) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (enable) state_next = S_RUN;
                S_RUN: begin
                    if (!enable)               state_next = S_IDLE;
                    else if (tick && err_any)  state_next = S_FAIL;
                    else if (pass_hit)         state_next = S_PASS;
                    else if (tout_hit)         state_next = S_TOUT;
                end
                default: state_next = state;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state <= S_IDLE;
        else         state <= state_next;
    end

    // History FIFO handshake: a push into a full FIFO is only kept when a pop frees a slot.
    always_comb begin
        pop     = hist_valid && hist_ready && !clear;
        full    = (hist_count == CW'(HIST_DEPTH));
        push_ok = accept && (!full || pop);
    end

    // History storage; no reset so it maps onto RAM, pointers give it meaning.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= stage_s2;
    end

    // Prescaler, debounce, watchdog, verdict flags and FIFO bookkeeping.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            presc      <= '0;
            wd         <= '0;
            cand       <= '0;
            stage_q    <= '0;
            stage_evt  <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            err_src    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hist_count <= '0;
            hist_ovf   <= 1'b0;
        end else if (clear) begin
            presc      <= '0;
            wd         <= '0;
            cand       <= '0;
            stage_q    <= '0;
            stage_evt  <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            timeout    <= 1'b0;
            err_src    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hist_count <= '0;
            hist_ovf   <= 1'b0;
        end else begin
            stage_evt <= accept;
            if (state == S_RUN && !enable) begin
                presc <= '0;
                wd    <= '0;
            end else if (state == S_RUN) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick) begin
                    if (err_any) begin
                        fail    <= 1'b1;
                        err_src <= err_s2;
                    end else begin
                        cand <= stage_s2;
                        if (accept)   stage_q <= stage_s2;
                        if (pass_hit) pass    <= 1'b1;
                        wd <= wd_zero ? '0 : wd_inc;
                        if (tout_hit) timeout <= 1'b1;
                    end
                end
            end

            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      hist_count <= hist_count + 1'b1;
            else if (pop && !push_ok) hist_count <= hist_count - 1'b1;
            if (accept && full && !pop) hist_ovf <= 1'b1;
        end
    end

    assign done       = pass | fail | timeout;
    assign hist_valid = (hist_count != '0);
    assign hist_data  = hist_valid ? mem[rd_ptr] : '0;

endmodule
